// File: rtl/nic8_pkg.sv
//------------------------------------------------------------------------------
// nic8_pkg : shared defaults, register indices and decoder control fields
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nic8_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_NREGS     = 4;
   localparam int DEF_OUT_DEPTH = 2;

   localparam int REG_A = 0;
   localparam int REG_B = 1;
   localparam int REG_X = 2;
   localparam int REG_Q = 3;

   // Control bits produced by the instruction decoder for one cycle
   typedef struct packed {
      logic load_ir;
      logic pc_inc;
      logic pc_load;
      logic jump_cond;
      logic wr_en;
      logic flag_we;
      logic out_we;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/out_fifo.sv
//------------------------------------------------------------------------------
// out_fifo : circular ready/valid output buffer with sticky overflow flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module out_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_req,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             full,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic w_valid;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == c_DEPTH);
   assign w_pop   = w_valid && ready;
   // A full buffer still accepts a push when the head leaves in the same cycle
   assign w_push  = push_req && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (push_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= push_data;
   end

   assign data     = r_mem[r_rd_ptr];
   assign valid    = w_valid;
   assign full     = w_full;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/register_bank.sv
//------------------------------------------------------------------------------
// register_bank : IR, PC, general registers, flags and buffered output channel
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module register_bank
   import nic8_pkg::*;
#(
   parameter  int WIDTH     = DEF_WIDTH,
   parameter  int NREGS     = DEF_NREGS,
   parameter  int OUT_DEPTH = DEF_OUT_DEPTH,
   localparam int SELW      = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_ir,
   input  logic [WIDTH-1:0] ir_in,
   input  logic             pc_inc,
   input  logic             pc_load,
   input  logic             jump_cond,
   input  logic [WIDTH-1:0] pc_target,
   input  logic             wr_en,
   input  logic [SELW-1:0]  wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [SELW-1:0]  rd_sel_a,
   input  logic [SELW-1:0]  rd_sel_b,
   input  logic             flag_we,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             out_we,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ir,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] rd_a,
   output logic [WIDTH-1:0] rd_b,
   output logic             flag_carry,
   output logic             flag_zero,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_full,
   output logic             out_overflow
);

   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_regs [NREGS];
   logic             r_carry;
   logic             r_zero;

   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;

   // IR falls back to zero (NOP) on every cycle without a load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir    <= '0;
         r_pc    <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_ir <= load_ir ? ir_in : '0;
         if (pc_load && jump_cond) r_pc <= pc_target;
         else if (pc_inc)          r_pc <= r_pc + WIDTH'(1);
         if (flag_we) begin
            r_carry <= carry_in;
            r_zero  <= (alu_result == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (wr_en && (int'(wr_sel) < NREGS)) begin
         r_regs[wr_sel] <= wr_data;
      end
   end

   // Reads see registered state only; a same-cycle write appears next cycle
   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      if (int'(rd_sel_a) < NREGS) w_rd_a = r_regs[rd_sel_a];
      if (int'(rd_sel_b) < NREGS) w_rd_b = r_regs[rd_sel_b];
   end

   out_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_req  (out_we),
      .push_data (wr_data),
      .ready     (out_ready),
      .data      (out_data),
      .valid     (out_valid),
      .full      (out_full),
      .overflow  (out_overflow)
   );

   assign ir         = r_ir;
   assign pc         = r_pc;
   assign rd_a       = w_rd_a;
   assign rd_b       = w_rd_b;
   assign flag_carry = r_carry;
   assign flag_zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
//------------------------------------------------------------------------------
// tb_register_bank : directed self-checking bench for register_bank
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_ir;
   logic [7:0] ir_in;
   logic       pc_inc;
   logic       pc_load;
   logic       jump_cond;
   logic [7:0] pc_target;
   logic       wr_en;
   logic [1:0] wr_sel;
   logic [7:0] wr_data;
   logic [1:0] rd_sel_a;
   logic [1:0] rd_sel_b;
   logic       flag_we;
   logic       carry_in;
   logic [7:0] alu_result;
   logic       out_we;
   logic       out_ready;
   logic [7:0] ir;
   logic [7:0] pc;
   logic [7:0] rd_a;
   logic [7:0] rd_b;
   logic       flag_carry;
   logic       flag_zero;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_full;
   logic       out_overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   register_bank dut (
      .clk          (clk),
      .reset        (reset),
      .load_ir      (load_ir),
      .ir_in        (ir_in),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .jump_cond    (jump_cond),
      .pc_target    (pc_target),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_data      (wr_data),
      .rd_sel_a     (rd_sel_a),
      .rd_sel_b     (rd_sel_b),
      .flag_we      (flag_we),
      .carry_in     (carry_in),
      .alu_result   (alu_result),
      .out_we       (out_we),
      .out_ready    (out_ready),
      .ir           (ir),
      .pc           (pc),
      .rd_a         (rd_a),
      .rd_b         (rd_b),
      .flag_carry   (flag_carry),
      .flag_zero    (flag_zero),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_full     (out_full),
      .out_overflow (out_overflow)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; load_ir = 0; ir_in = 0; pc_inc = 0; pc_load = 0; jump_cond = 0;
      pc_target = 0; wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel_a = 0; rd_sel_b = 0;
      flag_we = 0; carry_in = 0; alu_result = 0; out_we = 0; out_ready = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      tick(); tick();
      reset = 0;
      tick(); tick(); tick();
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL reset_ir got=%h exp=00", ir); end
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
      checks++; if (rd_a !== 8'h00 || rd_b !== 8'h00) begin failures++; $display("FAIL reset_rd got=%h/%h exp=00/00", rd_a, rd_b); end
      checks++; if ({flag_carry, flag_zero} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", flag_carry, flag_zero); end
      checks++; if ({out_valid, out_full, out_overflow} !== 3'b000) begin failures++; $display("FAIL reset_fifo got v=%b f=%b o=%b exp=000", out_valid, out_full, out_overflow); end
   endtask

   task automatic test_pc();
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
      pc_load = 1; jump_cond = 1; pc_target = 8'hFE;
      tick();
      checks++; if (pc !== 8'hFE) begin failures++; $display("FAIL pc_jump_fe got=%h exp=fe", pc); end
      pc_load = 0; jump_cond = 0; pc_inc = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc !== exp_seq[i]) begin failures++; $display("FAIL pc_inc_wrap[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
      end
      pc_load = 1; jump_cond = 1; pc_target = 8'h40;
      tick();
      checks++; if (pc !== 8'h40) begin failures++; $display("FAIL pc_jump_over_inc got=%h exp=40", pc); end
      jump_cond = 0;
      tick();
      checks++; if (pc !== 8'h41) begin failures++; $display("FAIL pc_nojump_inc got=%h exp=41", pc); end
      pc_load = 0; pc_inc = 0;
      tick();
      checks++; if (pc !== 8'h41) begin failures++; $display("FAIL pc_hold got=%h exp=41", pc); end
   endtask

   task automatic test_regs_ir();
      wr_en = 1; wr_sel = 2; wr_data = 8'h5A; rd_sel_a = 2; rd_sel_b = 2;
      #1;
      checks++; if (rd_a !== 8'h00) begin failures++; $display("FAIL rd_no_bypass got=%h exp=00", rd_a); end
      tick();
      wr_sel = 0; wr_data = 8'hA5; rd_sel_b = 0;
      #1;
      checks++; if (rd_a !== 8'h5A) begin failures++; $display("FAIL rd_a_after_wr got=%h exp=5a", rd_a); end
      checks++; if (rd_b !== 8'h00) begin failures++; $display("FAIL rd_b_reg0_old got=%h exp=00", rd_b); end
      tick();
      wr_en = 0;
      checks++; if (rd_b !== 8'hA5 || rd_a !== 8'h5A) begin failures++; $display("FAIL rd_dual got=%h/%h exp=5a/a5", rd_a, rd_b); end
      load_ir = 1; ir_in = 8'h33;
      tick();
      load_ir = 0;
      checks++; if (ir !== 8'h33) begin failures++; $display("FAIL ir_load got=%h exp=33", ir); end
      tick();
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL ir_nop got=%h exp=00", ir); end
   endtask

   task automatic test_flags();
      flag_we = 1; carry_in = 1; alu_result = 8'h00;
      tick();
      checks++; if ({flag_carry, flag_zero} !== 2'b11) begin failures++; $display("FAIL flags_set got=%b%b exp=11", flag_carry, flag_zero); end
      flag_we = 0; carry_in = 0; alu_result = 8'h07;
      tick();
      checks++; if ({flag_carry, flag_zero} !== 2'b11) begin failures++; $display("FAIL flags_hold got=%b%b exp=11", flag_carry, flag_zero); end
      flag_we = 1;
      tick();
      flag_we = 0;
      checks++; if ({flag_carry, flag_zero} !== 2'b00) begin failures++; $display("FAIL flags_clear got=%b%b exp=00", flag_carry, flag_zero); end
   endtask

   task automatic test_fifo_overflow();
      out_ready = 0; out_we = 1; wr_data = 8'h11;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_full !== 1'b0) begin failures++; $display("FAIL fifo_push1 got v=%b d=%h f=%b exp v=1 d=11 f=0", out_valid, out_data, out_full); end
      wr_data = 8'h22;
      tick();
      checks++; if (out_full !== 1'b1 || out_overflow !== 1'b0) begin failures++; $display("FAIL fifo_full got f=%b o=%b exp f=1 o=0", out_full, out_overflow); end
      wr_data = 8'h33;
      tick();
      out_we = 0;
      checks++; if (out_overflow !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL fifo_overflow got o=%b d=%h exp o=1 d=11", out_overflow, out_data); end
      out_ready = 1;
      tick();
      checks++; if (out_data !== 8'h22 || out_valid !== 1'b1 || out_full !== 1'b0) begin failures++; $display("FAIL fifo_pop1 got d=%h v=%b f=%b exp d=22 v=1 f=0", out_data, out_valid, out_full); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_overflow !== 1'b1) begin failures++; $display("FAIL fifo_drain got v=%b o=%b exp v=0 o=1", out_valid, out_overflow); end
      out_ready = 0;
   endtask

   task automatic test_back_to_back();
      reset = 1;
      tick();
      reset = 0;
      rd_sel_a = 2;
      #1;
      checks++; if (out_overflow !== 1'b0 || rd_a !== 8'h00) begin failures++; $display("FAIL rereset got o=%b rd_a=%h exp o=0 rd_a=00", out_overflow, rd_a); end
      out_we = 1; wr_data = 8'h11;
      tick();
      wr_data = 8'h22;
      tick();
      wr_data = 8'h44; out_ready = 1;
      tick();
      out_we = 0;
      checks++; if (out_full !== 1'b1 || out_overflow !== 1'b0 || out_data !== 8'h22) begin failures++; $display("FAIL push_pop_full got f=%b o=%b d=%h exp f=1 o=0 d=22", out_full, out_overflow, out_data); end
      tick();
      out_ready = 0;
      checks++; if (out_data !== 8'h44 || out_full !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL pop_after_pp got d=%h f=%b v=%b exp d=44 f=0 v=1", out_data, out_full, out_valid); end
      out_we = 1; wr_data = 8'h55;
      tick();
      wr_data = 8'h66; reset = 1; pc_inc = 1;
      tick();
      reset = 0; out_we = 0; pc_inc = 0;
      checks++; if (out_valid !== 1'b0 || out_full !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL mid_reset got v=%b f=%b pc=%h exp v=0 f=0 pc=00", out_valid, out_full, pc); end
   endtask

   initial begin
      test_reset();
      test_pc();
      test_regs_ir();
      test_flags();
      test_fifo_overflow();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the nic8 CPU register set: instruction register, program counter, N general-purpose registers, carry/zero flags, and a buffered output channel.
- Sits between control decode and datapath buses.
- Adds over the fixed 8-bit version: width/count parameters, addressed write and dual read ports, priority-defined PC update, a zero flag, and a ready/valid output FIFO with overflow flag.

Parameters:
WIDTH, 8, data/address width of every register and bus
NREGS, 4, number of general-purpose registers (>=2)
SELW, $clog2(NREGS), register select width (derived localparam)
OUT_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
load_ir  in  1  capture ir_in into ir
ir_in  in  WIDTH  instruction from memory bus
pc_inc  in  1  increment PC (immediate fetch)
pc_load  in  1  jump request
jump_cond  in  1  jump condition; jump taken only when pc_load && jump_cond
pc_target  in  WIDTH  jump address
wr_en  in  1  general-register write enable
wr_sel  in  SELW  register to write
wr_data  in  WIDTH  write data (data bus)
rd_sel_a  in  SELW  read port A select
rd_sel_b  in  SELW  read port B select
flag_we  in  1  update flags (ALU result cycle)
carry_in  in  1  ALU carry out
alu_result  in  WIDTH  ALU result, used for zero flag
out_we  in  1  push wr_data into output FIFO
out_ready  in  1  consumer accepts head entry
ir  out  WIDTH  instruction register
pc  out  WIDTH  program counter
rd_a  out  WIDTH  combinational read of reg[rd_sel_a]
rd_b  out  WIDTH  combinational read of reg[rd_sel_b]
flag_carry  out  1  carry flag
flag_zero  out  1  zero flag
out_data  out  WIDTH  FIFO head
out_valid  out  1  FIFO non-empty
out_full  out  1  FIFO full
out_overflow  out  1  sticky: push attempted while full and not popping

Behaviour:
- Reset (sync, highest priority): ir, pc, all regs, flags, FIFO pointers/count, out_overflow all 0; out_valid=0, out_full=0.
- ir: next = load_ir ? ir_in : 0 (cleared on any cycle without load_ir, injects NOP).
- pc priority: (pc_load && jump_cond) -> pc_target; else pc_inc -> pc+1 mod 2^WIDTH (wraps all-ones -> 0); else hold. Jump taken overrides simultaneous pc_inc.
- General regs: wr_en writes reg[wr_sel] on posedge. wr_sel >= NREGS ignored (no write).
- Reads: rd_a/rd_b purely combinational from current state. No write-through bypass: same-cycle write shows on next cycle. Out-of-range select returns 0.
- Flags: flag_we -> flag_carry<=carry_in, flag_zero<=(alu_result==0). Otherwise hold.
- Output FIFO: circular, OUT_DEPTH entries.
  - pop = out_valid && out_ready.
  - push = out_we && (!out_full || pop).
  - Simultaneous push+pop is legal when full or empty-with-pop-impossible. Count unchanged on push+pop.
  - out_data = head entry; value undefined-but-stable (hold last) when empty.
  - Push-to-pop latency 1 cycle: pushed data visible on out_data, out_valid=1 the next cycle.
  - out_we while full and no pop: data dropped, out_overflow<=1, sticky until reset.
  - Pointers wrap modulo OUT_DEPTH. out_full = (count==OUT_DEPTH).
- Reset mid-operation: discards FIFO contents and any in-flight update that cycle.

Decomposition:
- Shared package nic8_pkg: localparam defaults (WIDTH, NREGS), register-index constants (REG_A=0, REG_B=1, REG_X=2, REG_Q=3), control-bit field struct for the decoder.
- One sub-module: out_fifo (WIDTH, OUT_DEPTH; push/pop/full/valid/overflow). Register file, PC, IR, and flags stay inline.

Test Plan:
- Reset then idle 3 cycles -> ir=0, pc=0, rd_a=rd_b=0, flags 0, out_valid=0, out_overflow=0.
- pc_inc from pc=8'hFE for 3 cycles -> pc FF, 00, 01. Then pc_load=1, jump_cond=1, pc_inc=1, pc_target=8'h40 -> pc=40. With jump_cond=0 -> pc=41.
- wr_en, wr_sel=2, wr_data=8'h5A with rd_sel_a=2 -> rd_a old value in the write cycle, 5A the next. load_ir pulse with ir_in=8'h33 -> ir=33 for one cycle, then 0.
- flag_we with carry_in=1, alu_result=0 -> carry=1, zero=1. Then flag_we=0 with alu_result=7 -> flags hold.
- out_ready=0, push 11, 22, 33 -> out_full=1 after 2 pushes, 33 dropped, out_overflow=1. Then out_ready=1 -> out_data 11 then 22, out_valid falls, overflow stays 1.
- FIFO full, push 44 with out_ready=1 same cycle -> 11 popped, 44 accepted, no overflow, count stays 2. Assert reset mid-stream -> FIFO empty next cycle.
